// File: rtl/door_load_controller_if.sv
// Car-level door handshake bundle: event inputs from floor/button logic
// and door/load status back to the motion controller.
interface door_load_controller_if #(
   parameter int CNT_W = 3
);
   logic             arrive;
   logic             board;
   logic             leave;
   logic             open_req;
   logic             close_req;
   logic             door;
   logic             closing;
   logic             overweight;
   logic             depart_ok;
   logic [CNT_W-1:0] load;

   modport master (
      output arrive, board, leave, open_req, close_req,
      input  door, closing, overweight, depart_ok, load
   );

   modport slave (
      input  arrive, board, leave, open_req, close_req,
      output door, closing, overweight, depart_ok, load
   );
endinterface

// File: rtl/door_load_controller.sv
// Door sequencer with saturating passenger load counter; holds the door
// open while overweight and pulses depart_ok when fully closed.
module door_load_controller #(
   parameter int LIMIT        = 5,
   parameter int CNT_W        = 3,
   parameter int OPEN_CYCLES  = 8,
   parameter int CLOSE_CYCLES = 4,
   parameter int TMR_W        = 4
) (
   input logic             clk,
   input logic             weight_flip_reset,
   door_load_controller_if.slave bus
);

   typedef enum logic [1:0] {
      CLOSED  = 2'd0,
      OPEN    = 2'd1,
      CLOSING = 2'd2
   } state_t;

   localparam logic [TMR_W-1:0] OPEN_LD  = TMR_W'(OPEN_CYCLES - 1);
   localparam logic [TMR_W-1:0] CLOSE_LD = TMR_W'(CLOSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOAD_MAX = '1;
   localparam logic [CNT_W-1:0] LIMIT_V  = CNT_W'(LIMIT);

   state_t           state;
   logic [TMR_W-1:0] timer;
   logic [CNT_W-1:0] load_q;
   logic [CNT_W-1:0] load_nxt;
   logic             door_q;
   logic             closing_q;
   logic             depart_q;
   logic             heavy;
   logic             reopen;

   // Decoded from the registered count, so a board on this edge
   // only affects overweight from the next cycle on.
   assign heavy  = load_q > LIMIT_V;
   assign reopen = bus.open_req | bus.arrive | bus.board | heavy;

   always_comb begin
      load_nxt = load_q;
      if (bus.board && !bus.leave && load_q != LOAD_MAX)
         load_nxt = load_q + 1'b1;
      else if (bus.leave && !bus.board && load_q != '0)
         load_nxt = load_q - 1'b1;
   end

   always_ff @(posedge clk or posedge weight_flip_reset) begin
      if (weight_flip_reset) begin
         state     <= CLOSED;
         timer     <= '0;
         load_q    <= '0;
         door_q    <= 1'b0;
         closing_q <= 1'b0;
         depart_q  <= 1'b0;
      end else begin
         depart_q <= 1'b0;
         if (door_q)
            load_q <= load_nxt;
         case (state)
            CLOSED: begin
               if (bus.arrive || bus.open_req) begin
                  state  <= OPEN;
                  timer  <= OPEN_LD;
                  door_q <= 1'b1;
               end
            end
            OPEN: begin
               if (reopen) begin
                  timer <= OPEN_LD;
               end else if (bus.close_req || timer == '0) begin
                  state     <= CLOSING;
                  timer     <= CLOSE_LD;
                  closing_q <= 1'b1;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            CLOSING: begin
               if (reopen) begin
                  state     <= OPEN;
                  timer     <= OPEN_LD;
                  closing_q <= 1'b0;
               end else if (timer == '0) begin
                  state     <= CLOSED;
                  door_q    <= 1'b0;
                  closing_q <= 1'b0;
                  depart_q  <= 1'b1;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            default: begin
               state     <= CLOSED;
               timer     <= '0;
               door_q    <= 1'b0;
               closing_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.door       = door_q;
   assign bus.closing    = closing_q;
   assign bus.depart_ok  = depart_q;
   assign bus.overweight = heavy;
   assign bus.load       = load_q;

endmodule

// File: tb/tb_door_load_controller.sv
// Bench for door_load_controller: vector table, corner sequences and
// random traffic against a dwell-count reference model.
module tb_door_load_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   door_load_controller_if #(.CNT_W(3)) bus ();

   door_load_controller dut (
      .clk               (clk),
      .weight_flip_reset (rst),
      .bus               (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit a, b, l, o, c;
      bit dr, cl, ow, dp;
      int ld;
   } vec_t;

   vec_t tbl[$];

   // Reference: mode 0 closed, 1 open, 2 closing; left = cycles remaining.
   int m_mode = 0;
   int m_left = 0;
   int m_load = 0;
   bit m_dep  = 0;

   function automatic vec_t vec(bit a, bit b, bit l, bit o, bit c,
                                bit dr, bit cl, int ld, bit ow, bit dp);
      vec_t v;
      v.a = a; v.b = b; v.l = l; v.o = o; v.c = c;
      v.dr = dr; v.cl = cl; v.ld = ld; v.ow = ow; v.dp = dp;
      return v;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_left = 0; m_load = 0; m_dep = 0;
   endtask

   task automatic model_step(bit a, bit b, bit l, bit o, bit c);
      bit was_open, ow, reopen;
      was_open = (m_mode != 0);
      ow       = (m_load > 5);
      reopen   = o | a | b | ow;
      m_dep    = 0;
      if (m_mode == 0) begin
         if (a | o) begin m_mode = 1; m_left = 8; end
      end else if (m_mode == 1) begin
         if (reopen) m_left = 8;
         else if (c || m_left == 1) begin m_mode = 2; m_left = 4; end
         else m_left--;
      end else begin
         if (reopen) begin m_mode = 1; m_left = 8; end
         else if (m_left == 1) begin m_mode = 0; m_dep = 1; end
         else m_left--;
      end
      if (was_open) begin
         if (b && !l && m_load < 7) m_load++;
         else if (l && !b && m_load > 0) m_load--;
      end
   endtask

   task automatic check_model(string tag);
      chk({tag, "_door"}, int'(bus.door), int'(m_mode != 0));
      chk({tag, "_closing"}, int'(bus.closing), int'(m_mode == 2));
      chk({tag, "_load"}, int'(bus.load), m_load);
      chk({tag, "_overweight"}, int'(bus.overweight), int'(m_load > 5));
      chk({tag, "_depart"}, int'(bus.depart_ok), int'(m_dep));
   endtask

   task automatic cycle(bit a, bit b, bit l, bit o, bit c);
      bus.arrive = a; bus.board = b; bus.leave = l;
      bus.open_req = o; bus.close_req = c;
      @(posedge clk);
      model_step(a, b, l, o, c);
      #1;
      check_model("mdl");
   endtask

   task automatic idle(int n);
      repeat (n) cycle(0, 0, 0, 0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.arrive = 0; bus.board = 0; bus.leave = 0;
      bus.open_req = 0; bus.close_req = 0;

      // T1: undisturbed dwell after arrive
      tbl.push_back(vec(1,0,0,0,0, 1,0,0,0,0));
      for (int i = 1; i <= 7; i++) tbl.push_back(vec(0,0,0,0,0, 1,0,0,0,0));
      for (int i = 8; i <= 11; i++) tbl.push_back(vec(0,0,0,0,0, 1,1,0,0,0));
      tbl.push_back(vec(0,0,0,0,0, 0,0,0,0,1));
      tbl.push_back(vec(0,0,0,0,0, 0,0,0,0,0));
      // T3: early close_req with two passengers
      tbl.push_back(vec(1,0,0,0,0, 1,0,0,0,0));
      tbl.push_back(vec(0,1,0,0,0, 1,0,1,0,0));
      tbl.push_back(vec(0,1,0,0,0, 1,0,2,0,0));
      tbl.push_back(vec(0,0,0,0,1, 1,1,2,0,0));
      for (int i = 0; i < 3; i++) tbl.push_back(vec(0,0,0,0,0, 1,1,2,0,0));
      tbl.push_back(vec(0,0,0,0,0, 0,0,2,0,1));
      tbl.push_back(vec(0,0,0,0,0, 0,0,2,0,0));
      tbl.push_back(vec(0,1,0,0,0, 0,0,2,0,0));

      repeat (2) @(posedge clk);
      #1;
      chk("rst_door", int'(bus.door), 0);
      chk("rst_closing", int'(bus.closing), 0);
      chk("rst_load", int'(bus.load), 0);
      chk("rst_overweight", int'(bus.overweight), 0);
      chk("rst_depart", int'(bus.depart_ok), 0);
      @(negedge clk);
      rst = 0;
      model_reset();

      foreach (tbl[i]) begin
         cycle(tbl[i].a, tbl[i].b, tbl[i].l, tbl[i].o, tbl[i].c);
         chk($sformatf("tbl%0d_door", i), int'(bus.door), int'(tbl[i].dr));
         chk($sformatf("tbl%0d_closing", i), int'(bus.closing), int'(tbl[i].cl));
         chk($sformatf("tbl%0d_load", i), int'(bus.load), tbl[i].ld);
         chk($sformatf("tbl%0d_ow", i), int'(bus.overweight), int'(tbl[i].ow));
         chk($sformatf("tbl%0d_depart", i), int'(bus.depart_ok), int'(tbl[i].dp));
      end

      // T2: overweight holds the door, close_req ignored
      cycle(1,0,0,0,0);
      repeat (4) cycle(0,1,0,0,0);
      chk("t2_load6", int'(bus.load), 6);
      chk("t2_ow", int'(bus.overweight), 1);
      for (int i = 0; i < 20; i++) cycle(0,0,0,0,i % 2);
      chk("t2_hold", int'(bus.door), 1);
      chk("t2_hold_cl", int'(bus.closing), 0);
      cycle(0,0,1,0,0);
      chk("t2_load5", int'(bus.load), 5);
      chk("t2_ow_off", int'(bus.overweight), 0);
      idle(7);
      chk("t2_still_open", int'(bus.closing), 0);
      idle(1);
      chk("t2_closing", int'(bus.closing), 1);
      idle(4);
      chk("t2_depart", int'(bus.depart_ok), 1);

      // T4: reopen in second CLOSING cycle
      cycle(1,0,0,0,0);
      idle(8);
      chk("t4_closing", int'(bus.closing), 1);
      idle(1);
      cycle(0,0,0,1,0);
      chk("t4_reopen", int'(bus.closing), 0);
      chk("t4_door", int'(bus.door), 1);
      idle(7);
      chk("t4_full_dwell", int'(bus.closing), 0);
      chk("t4_no_depart", int'(bus.depart_ok), 0);
      idle(1);
      chk("t4_closing2", int'(bus.closing), 1);
      idle(4);

      // T5: saturation at both ends, simultaneous board/leave
      cycle(1,0,0,0,0);
      repeat (9) cycle(0,1,0,0,0);
      chk("t5_sat", int'(bus.load), 7);
      chk("t5_ow", int'(bus.overweight), 1);
      cycle(0,1,1,0,0);
      chk("t5_both", int'(bus.load), 7);
      repeat (8) cycle(0,0,1,0,0);
      chk("t5_zero", int'(bus.load), 0);
      idle(12);
      chk("t5_closed", int'(bus.door), 0);
      cycle(0,1,0,0,0);
      chk("t5_board_closed", int'(bus.load), 0);

      // T6: asynchronous reset mid-CLOSING
      cycle(1,0,0,0,0);
      cycle(0,1,0,0,0);
      cycle(0,1,0,0,0);
      idle(9);
      chk("t6_pre", int'(bus.closing), 1);
      @(negedge clk);
      rst = 1;
      #1;
      model_reset();
      chk("t6_door", int'(bus.door), 0);
      chk("t6_closing", int'(bus.closing), 0);
      chk("t6_load", int'(bus.load), 0);
      chk("t6_depart", int'(bus.depart_ok), 0);
      @(negedge clk);
      rst = 0;
      idle(5);
      chk("t6_stay_closed", int'(bus.door), 0);
      cycle(1,0,0,0,0);
      chk("t6_arrive", int'(bus.door), 1);

      // random traffic against the model
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(19) == 0, $urandom_range(6) == 0,
               $urandom_range(5) == 0, $urandom_range(24) == 0,
               $urandom_range(9) == 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
